// File: rtl/regfile_arb_pkg.sv
// Shared widths, RegFile operation encoding and client ids for the register-file port arbiter.
package regfile_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  localparam logic CLIENT_0 = 1'b0;
  localparam logic CLIENT_1 = 1'b1;

  function automatic logic [1:0] client_onehot(input logic client);
    return (client == CLIENT_1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot combinational grant, pointer moves past the winner on advance.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = client_onehot(ptr);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= CLIENT_0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0] ? CLIENT_1 : CLIENT_0;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one RegFile (one op per cycle) between two write clients and two read clients,
// registering all RegFile controls and returning read data with a per-client valid pulse.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = 1,
  parameter int STARVE_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  input  logic [1:0]        rd_req,
  input  logic [ADDR_W-1:0] rd_rs1_0,
  input  logic [ADDR_W-1:0] rd_rs1_1,
  input  logic [ADDR_W-1:0] rd_rs2_0,
  input  logic [ADDR_W-1:0] rd_rs2_1,
  output logic [1:0]        rd_gnt,
  output logic [1:0]        rd_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rf_EN,
  output logic              rf_WR,
  output logic              rf_RD,
  output logic [ADDR_W-1:0] rf_DR,
  output logic [DATA_W-1:0] rf_Data_in,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_BusA,
  input  logic [DATA_W-1:0] rf_BusB
);

  localparam int CNT_W = (STARVE_N > 0) ? $clog2(STARVE_N + 1) : 1;

  logic [1:0]       wr_arb_gnt, rd_arb_gnt;
  logic             wr_any, rd_any, read_wins, write_wins;
  logic [CNT_W-1:0] starve_cnt;
  op_e              op_q;
  logic             rd_tag_q;
  logic             pipe_in_v, exit_v, exit_tag;

  always_comb begin
    wr_any     = |wr_req;
    rd_any     = |rd_req;
    read_wins  = rd_any && (!wr_any || (starve_cnt == CNT_W'(STARVE_N)));
    write_wins = wr_any && !read_wins;
  end

  assign wr_gnt = write_wins ? wr_arb_gnt : 2'b00;
  assign rd_gnt = read_wins  ? rd_arb_gnt : 2'b00;

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .advance (write_wins),
    .gnt     (wr_arb_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .advance (read_wins),
    .gnt     (rd_arb_gnt)
  );

  // A read that keeps losing to writes accumulates credit until it is forced through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!rd_any || read_wins) begin
      starve_cnt <= '0;
    end else if (write_wins && (starve_cnt != CNT_W'(STARVE_N))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= OP_IDLE;
      rf_EN      <= 1'b0;
      rf_WR      <= 1'b0;
      rf_RD      <= 1'b0;
      rf_DR      <= '0;
      rf_Data_in <= '0;
      rf_rs1     <= '0;
      rf_rs2     <= '0;
      rd_tag_q   <= CLIENT_0;
    end else begin
      rf_EN <= 1'b1;
      rf_WR <= write_wins;
      rf_RD <= read_wins;
      if (write_wins) begin
        op_q       <= OP_WRITE;
        rf_DR      <= wr_gnt[1] ? wr_addr1 : wr_addr0;
        rf_Data_in <= wr_gnt[1] ? wr_data1 : wr_data0;
      end else if (read_wins) begin
        op_q     <= OP_READ;
        rf_rs1   <= rd_gnt[1] ? rd_rs1_1 : rd_rs1_0;
        rf_rs2   <= rd_gnt[1] ? rd_rs2_1 : rd_rs2_0;
        rd_tag_q <= rd_gnt[1] ? CLIENT_1 : CLIENT_0;
      end else begin
        op_q <= OP_IDLE;
      end
    end
  end

  assign pipe_in_v = (op_q == OP_READ);

  generate
    if (READ_LAT == 0) begin : g_no_pipe
      assign exit_v   = pipe_in_v;
      assign exit_tag = rd_tag_q;
    end else begin : g_pipe
      logic [READ_LAT-1:0] pipe_v, pipe_tag;

      // NOTE: the tag pipe is reset (not left as free-running storage) so in-flight reads are dropped on reset.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_v   <= '0;
          pipe_tag <= '0;
        end else begin
          pipe_v[0]   <= pipe_in_v;
          pipe_tag[0] <= rd_tag_q;
          for (int i = 1; i < READ_LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
          end
        end
      end

      assign exit_v   = pipe_v[READ_LAT-1];
      assign exit_tag = pipe_tag[READ_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid  <= 2'b00;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_valid <= exit_v ? client_onehot(exit_tag) : 2'b00;
      if (exit_v) begin
        rd_data_a <= rf_BusA;
        rd_data_b <= rf_BusB;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 1-cycle-latency register file.
module tb_regfile_port_arbiter;

  logic        clk, rst;
  logic [1:0]  wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
  logic [4:0]  wr_addr0, wr_addr1, rd_rs1_0, rd_rs1_1, rd_rs2_0, rd_rs2_1;
  logic [31:0] wr_data0, wr_data1, rd_data_a, rd_data_b;
  logic        rf_EN, rf_WR, rf_RD;
  logic [4:0]  rf_DR, rf_rs1, rf_rs2;
  logic [31:0] rf_Data_in, rf_BusA, rf_BusB;

  int checks = 0;
  int failures = 0;

  regfile_port_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_rs1_0(rd_rs1_0), .rd_rs1_1(rd_rs1_1),
    .rd_rs2_0(rd_rs2_0), .rd_rs2_1(rd_rs2_1), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rf_EN(rf_EN), .rf_WR(rf_WR), .rf_RD(rf_RD), .rf_DR(rf_DR),
    .rf_Data_in(rf_Data_in), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_BusA(rf_BusA), .rf_BusB(rf_BusB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: writes commit at the edge, reads appear one cycle after rf_RD.
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rf_BusA = 32'h0;
    rf_BusB = 32'h0;
  end
  always @(posedge clk) begin
    if (rf_EN && rf_WR) mem[rf_DR] <= rf_Data_in;
    if (rf_RD) begin
      rf_BusA <= mem[rf_rs1];
      rf_BusB <= mem[rf_rs2];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wr_req = 2'b00; wr_addr0 = 5'd0; wr_addr1 = 5'd0; wr_data0 = 32'h0; wr_data1 = 32'h0;
    rd_req = 2'b00; rd_rs1_0 = 5'd0; rd_rs2_0 = 5'd0; rd_rs1_1 = 5'd0; rd_rs2_1 = 5'd0;
  endtask

  typedef struct {
    logic [1:0]  wr_req;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  rd_req;
    logic [4:0]  r1_0, r2_0, r1_1, r2_1;
    logic [1:0]  x_wr_gnt, x_rd_gnt;
    logic        x_wr;
    logic [4:0]  x_dr;
    logic [31:0] x_din;
    logic        x_rd;
    logic [4:0]  x_rs1, x_rs2;
    logic [1:0]  x_valid;
    logic [31:0] x_da, x_db;
  } vec_t;

  // Each row is one cycle: x_* registered fields are what rf_*/rd_* show at the start of that
  // cycle, x_*_gnt is the combinational grant for the row's requests.
  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    int   lat;

    vecs[0]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b00, 2'b00, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[1]  = '{2'b11, 5'd0, 32'habcd_efab, 5'd1, 32'h0123_4567, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b01, 2'b00, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[2]  = '{2'b10, 5'd0, 32'h0,         5'd1, 32'h0123_4567, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b10, 2'b00, 1'b1, 5'd0, 32'habcd_efab, 1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[3]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b01, 5'd0, 5'd1, 5'd0, 5'd0,
                 2'b00, 2'b01, 1'b1, 5'd1, 32'h0123_4567, 1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[4]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b00, 2'b00, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd1, 2'b00, 32'h0,         32'h0};
    vecs[5]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b00, 2'b00, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[6]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b00, 2'b00, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 2'b01, 32'habcd_efab, 32'h0123_4567};
    vecs[7]  = '{2'b01, 5'd2, 32'h2222_2222, 5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b01, 2'b00, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[8]  = '{2'b11, 5'd4, 32'h4444_4444, 5'd3, 32'h3333_3333, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b10, 2'b00, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[9]  = '{2'b01, 5'd4, 32'h4444_4444, 5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b01, 2'b00, 1'b1, 5'd3, 32'h3333_3333, 1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[10] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b11, 5'd2, 5'd3, 5'd4, 5'd0,
                 2'b00, 2'b10, 1'b1, 5'd4, 32'h4444_4444, 1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[11] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b01, 5'd2, 5'd3, 5'd0, 5'd0,
                 2'b00, 2'b01, 1'b0, 5'd0, 32'h0,         1'b1, 5'd4, 5'd0, 2'b00, 32'h0,         32'h0};
    vecs[12] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b00, 2'b00, 1'b0, 5'd0, 32'h0,         1'b1, 5'd2, 5'd3, 2'b00, 32'h0,         32'h0};
    vecs[13] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b00, 2'b00, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 2'b10, 32'h4444_4444, 32'habcd_efab};
    vecs[14] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b00, 2'b00, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 2'b01, 32'h2222_2222, 32'h3333_3333};
    vecs[15] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 5'd0, 5'd0, 5'd0, 5'd0,
                 2'b00, 2'b00, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 2'b00, 32'h0,         32'h0};

    // Reset state, then release.
    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("rst_en",    {31'h0, rf_EN}, 32'h0);
    check("rst_wr_rd", {30'h0, rf_WR, rf_RD}, 32'h0);
    check("rst_valid", {30'h0, rd_valid}, 32'h0);
    check("rst_gnt",   {28'h0, wr_gnt, rd_gnt}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      v = vecs[i];
      check($sformatf("v%0d_en", i),    {31'h0, rf_EN}, 32'h1);
      check($sformatf("v%0d_wr", i),    {31'h0, rf_WR}, {31'h0, v.x_wr});
      check($sformatf("v%0d_rd", i),    {31'h0, rf_RD}, {31'h0, v.x_rd});
      check($sformatf("v%0d_valid", i), {30'h0, rd_valid}, {30'h0, v.x_valid});
      if (v.x_wr) begin
        check($sformatf("v%0d_dr", i),  {27'h0, rf_DR}, {27'h0, v.x_dr});
        check($sformatf("v%0d_din", i), rf_Data_in, v.x_din);
      end
      if (v.x_rd) begin
        check($sformatf("v%0d_rs1", i), {27'h0, rf_rs1}, {27'h0, v.x_rs1});
        check($sformatf("v%0d_rs2", i), {27'h0, rf_rs2}, {27'h0, v.x_rs2});
      end
      if (v.x_valid != 2'b00) begin
        check($sformatf("v%0d_da", i), rd_data_a, v.x_da);
        check($sformatf("v%0d_db", i), rd_data_b, v.x_db);
      end
      wr_req = v.wr_req; wr_addr0 = v.wa0; wr_data0 = v.wd0; wr_addr1 = v.wa1; wr_data1 = v.wd1;
      rd_req = v.rd_req; rd_rs1_0 = v.r1_0; rd_rs2_0 = v.r2_0; rd_rs1_1 = v.r1_1; rd_rs2_1 = v.r2_1;
      #1;
      check($sformatf("v%0d_wr_gnt", i), {30'h0, wr_gnt}, {30'h0, v.x_wr_gnt});
      check($sformatf("v%0d_rd_gnt", i), {30'h0, rd_gnt}, {30'h0, v.x_rd_gnt});
    end

    // Starvation: continuous writes, pending read forced through on the 3rd cycle.
    @(negedge clk);
    wr_req = 2'b01; wr_addr0 = 5'd7; wr_data0 = 32'h7777_7777;
    rd_req = 2'b10; rd_rs1_1 = 5'd7; rd_rs2_1 = 5'd7;
    #1 check("starve_c1", {28'h0, wr_gnt, rd_gnt}, {28'h0, 2'b01, 2'b00});
    @(negedge clk);
    #1 check("starve_c2", {28'h0, wr_gnt, rd_gnt}, {28'h0, 2'b01, 2'b00});
    @(negedge clk);
    #1 check("starve_c3", {28'h0, wr_gnt, rd_gnt}, {28'h0, 2'b00, 2'b10});
    @(negedge clk);
    #1 check("starve_cleared", {28'h0, wr_gnt, rd_gnt}, {28'h0, 2'b01, 2'b00});
    @(negedge clk);
    wr_req = 2'b00;
    #1 check("starve_lone_rd", {28'h0, wr_gnt, rd_gnt}, {28'h0, 2'b00, 2'b10});
    @(negedge clk);
    drive_idle();
    repeat (6) @(negedge clk);

    // Same-cycle write and read of reg 5: write first, read sees the new data.
    wr_req = 2'b01; wr_addr0 = 5'd5; wr_data0 = 32'hdead_beef;
    rd_req = 2'b01; rd_rs1_0 = 5'd5; rd_rs2_0 = 5'd5;
    #1 check("raw_wr_first", {28'h0, wr_gnt, rd_gnt}, {28'h0, 2'b01, 2'b00});
    @(negedge clk);
    wr_req = 2'b00;
    #1 check("raw_rd_next", {28'h0, wr_gnt, rd_gnt}, {28'h0, 2'b00, 2'b01});
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      rd_req = 2'b00;
      if (rd_valid != 2'b00) begin
        lat = c;
        break;
      end
    end
    check("raw_latency", lat, 32'd3);
    check("raw_valid",   {30'h0, rd_valid}, 32'h1);
    check("raw_data_a",  rd_data_a, 32'hdead_beef);
    check("raw_data_b",  rd_data_b, 32'hdead_beef);
    drive_idle();
    repeat (3) @(negedge clk);

    // Reset the cycle after a read grant: outputs clear at once, the read never returns.
    rd_req = 2'b10; rd_rs1_1 = 5'd5; rd_rs2_1 = 5'd0;
    #1 check("rst_rd_gnt", {30'h0, rd_gnt}, 32'h2);
    @(negedge clk);
    drive_idle();
    check("rst_rd_live", {31'h0, rf_RD}, 32'h1);
    rst = 1'b0;
    #1;
    check("rst_async_ctl", {29'h0, rf_EN, rf_WR, rf_RD}, 32'h0);
    check("rst_async_idx", {22'h0, rf_rs1, rf_rs2}, 32'h0);
    check("rst_async_valid", {30'h0, rd_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rst_no_valid_%0d", c), {30'h0, rd_valid}, 32'h0);
    end

    // Reset while a write is on the RegFile bus: strobe drops immediately.
    wr_req = 2'b01; wr_addr0 = 5'd9; wr_data0 = 32'h9999_9999;
    #1 check("rstw_gnt", {30'h0, wr_gnt}, 32'h1);
    @(negedge clk);
    drive_idle();
    check("rstw_live", {26'h0, rf_WR, rf_DR}, {26'h0, 1'b1, 5'd9});
    rst = 1'b0;
    #1 check("rstw_wr_drop", {31'h0, rf_WR}, 32'h0);
    check("rstw_data_clr", rf_Data_in, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_en_back", {31'h0, rf_EN}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
